// File: rtl/cache_pkg.sv
// cache_pkg: shared cache types, line geometry and a log2 helper
package cache_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int CACHE_LINE_WORDS = 8;
    localparam int CACHE_OFF_W      = log2(CACHE_LINE_WORDS);

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry register FIFO that absorbs RAM read latency under backpressure
module skid_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok;

    // Apply pop first, then place the pushed word in the first free slot
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        pop_ok = pop && (occ_q != 2'd0);
        if (pop_ok) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0) head_d = push_data;
            else tail_d = push_data;
            occ_d = occ_d + 2'd1;
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/cache_line_reader.sv
// cache_line_reader: streams one cache line out of the data RAM over a valid/ready channel
module cache_line_reader
    import cache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    localparam int ADDR_WIDTH = log2(DEPTH),
    localparam int OFF_W      = (LINE_WORDS == CACHE_LINE_WORDS) ? CACHE_OFF_W : log2(LINE_WORDS),
    localparam int LINE_W     = ADDR_WIDTH - OFF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startValid,
    output logic                  startReady,
    input  logic [LINE_W-1:0]     startLine,
    output logic [ADDR_WIDTH-1:0] ramReadAddress,
    input  logic [WIDTH-1:0]      ramReadData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [WIDTH-1:0]      outData,
    output logic                  outLast,
    output logic                  busy
);

    rd_state_t             state_q, state_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [OFF_W:0]        issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]      send_cnt_q, send_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  start_hs, pop, issue, last_issue;
    logic [2:0]            pending;
    logic [1:0]            occ;
    logic [WIDTH-1:0]      head;

    skid_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .pop       (pop),
        .push_data (ramReadData),
        .head      (head),
        .occ       (occ)
    );

    assign startReady     = (state_q == IDLE);
    assign busy           = ~startReady;
    assign outValid       = (occ != 2'd0);
    assign outData        = head;
    assign outLast        = outValid && (send_cnt_q == OFF_W'(LINE_WORDS - 1));
    assign ramReadAddress = addr_d;

    // Issue reads only while FIFO slots plus the in-flight read leave room; sequence the line
    always_comb begin
        start_hs    = startValid && startReady;
        pop         = outValid && outReady;
        pending     = {1'b0, occ} + {2'b00, inflight_q};
        issue       = (state_q == READ) && (issue_cnt_q < (OFF_W+1)'(LINE_WORDS))
                      && (pending < (3'd2 + {2'b00, pop}));
        last_issue  = issue && (issue_cnt_q == (OFF_W+1)'(LINE_WORDS - 1));
        state_d     = state_q;
        if (state_q == IDLE && start_hs) state_d = READ;
        if (state_q == READ && last_issue) state_d = DRAIN;
        if (state_q == DRAIN && pop && outLast) state_d = IDLE;
        line_d      = start_hs ? startLine : line_q;
        issue_cnt_d = start_hs ? '0 : (issue ? issue_cnt_q + (OFF_W+1)'(1) : issue_cnt_q);
        send_cnt_d  = start_hs ? '0 : (pop ? send_cnt_q + OFF_W'(1) : send_cnt_q);
        addr_d      = issue ? {line_q, issue_cnt_q[OFF_W-1:0]} : addr_q;
        inflight_d  = issue;
    end

    // State, counters, held read address and the one-cycle RAM latency tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            issue_cnt_q <= '0;
            send_cnt_q  <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            issue_cnt_q <= issue_cnt_d;
            send_cnt_q  <= send_cnt_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_cache_line_reader.sv
// tb_cache_line_reader: table-driven and scoreboard checks of the line reader with a RAM model
module tb_cache_line_reader;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startValid = 1'b0;
    logic        outReady = 1'b0;
    logic [6:0]  startLine = '0;
    logic        startReady, outValid, outLast, busy;
    logic [9:0]  ramReadAddress;
    logic [31:0] ramReadData, outData;

    logic [31:0] mem [0:1023];
    logic [9:0]  ram_addr_q;

    typedef struct packed {logic [31:0] data; logic last;} exp_t;
    typedef struct {int line; logic [7:0] pat; int exp_min; int exp_max; int exp_first; int exp_time;} vec_t;

    exp_t q[$];
    vec_t vecs[5];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, hs_cyc = 0, first_pop = 0, last_pop = 0, pops_in_line = 0;
    int min_addr = 0, max_addr = 0, hs_count = 0, cur_base = 0;
    logic        stall_prev = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    cache_line_reader #(.WIDTH(32), .DEPTH(1024), .LINE_WORDS(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .startValid     (startValid),
        .startReady     (startReady),
        .startLine      (startLine),
        .ramReadAddress (ramReadAddress),
        .ramReadData    (ramReadData),
        .outValid       (outValid),
        .outReady       (outReady),
        .outData        (outData),
        .outLast        (outLast),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_addr_q <= ramReadAddress;
        cyc <= cyc + 1;
    end
    assign ramReadData = mem[ram_addr_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol monitor, sampled between clock edges
    always @(negedge clk) begin
        exp_t e;
        int off;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (busy) begin
                off = int'(ramReadAddress) - cur_base;
                if (int'(ramReadAddress) < min_addr) min_addr = int'(ramReadAddress);
                if (int'(ramReadAddress) > max_addr) max_addr = int'(ramReadAddress);
                chk("addr_window", 32'((off >= 0) && (off < LW) && (off <= pops_in_line + 2)), 32'd1);
            end
            if (stall_prev) chk("stall_hold", {outValid, outLast, outData[29:0]}, {1'b1, prev_last, prev_data[29:0]});
            if (outValid && outReady) begin
                chk("pop_has_expect", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_data", outData, e.data);
                    chk("out_last", 32'(outLast), 32'(e.last));
                end
                if (outLast) chk("no_ready_on_last_pop", 32'(startReady), 32'd0);
                if (pops_in_line == 0) first_pop = cyc;
                last_pop = cyc;
                pops_in_line++;
            end
            if (startValid && startReady) begin
                cur_base = int'(startLine) * LW;
                for (int k = 0; k < LW; k++) q.push_back({mem[cur_base + k], k == LW - 1});
                hs_cyc = cyc;
                hs_count++;
                pops_in_line = 0;
                min_addr = 1 << 20;
                max_addr = -1;
            end
            stall_prev = outValid && !outReady;
            prev_data  = outData;
            prev_last  = outLast;
        end
    end

    task automatic do_start(input int line);
        int h0;
        h0 = hs_count;
        startLine = 7'(line);
        startValid = 1'b1;
        for (int i = 0; i < 50 && hs_count == h0; i++) tick();
        chk("start_accepted", 32'(hs_count), 32'(h0 + 1));
        startValid = 1'b0;
    endtask

    task automatic run_until_idle(input logic [7:0] pat);
        int i;
        for (i = 0; i < 300; i++) begin
            outReady = pat[i % 8];
            tick();
            if (!busy) break;
        end
        chk("line_done_in_time", 32'(i < 300), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, h0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
        for (int i = 0; i < 8; i++) mem[8 + i] = 32'h100 + 32'(i);
        vecs[0] = '{1,   8'hFF,        8,    15,   3,  10};
        vecs[1] = '{1,   8'b1001_1001, 8,    15,   -1, -1};
        vecs[2] = '{127, 8'hFF,        1016, 1023, 3,  10};
        vecs[3] = '{5,   8'b0101_0101, 40,   47,   -1, -1};
        vecs[4] = '{0,   8'hFF,        0,    7,    3,  10};

        repeat (3) tick();
        chk("rst_startReady", 32'(startReady), 32'd1);
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_outLast", 32'(outLast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outData", outData, 32'd0);
        chk("rst_addr", 32'(ramReadAddress), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            outReady = vecs[v].pat[0];
            do_start(vecs[v].line);
            run_until_idle(vecs[v].pat);
            chk("min_addr", 32'(min_addr), 32'(vecs[v].exp_min));
            chk("max_addr", 32'(max_addr), 32'(vecs[v].exp_max));
            if (vecs[v].exp_first >= 0) chk("first_latency", 32'(first_pop - hs_cyc), 32'(vecs[v].exp_first));
            if (vecs[v].exp_time >= 0) chk("line_time", 32'(last_pop - hs_cyc), 32'(vecs[v].exp_time));
            chk("ready_after_line", 32'(startReady), 32'd1);
        end

        outReady = 1'b0;
        do_start(1);
        repeat (20) tick();
        chk("stall_max_addr", 32'(max_addr), 32'd9);
        chk("stall_min_addr", 32'(min_addr), 32'd8);
        chk("stall_outValid", 32'(outValid), 32'd1);
        chk("stall_outData", outData, 32'h100);
        chk("stall_outLast", 32'(outLast), 32'd0);
        run_until_idle(8'hFF);

        outReady = 1'b1;
        h0 = hs_count;
        startLine = 7'd2;
        startValid = 1'b1;
        for (int i = 0; i < 50 && hs_count == h0; i++) tick();
        t1 = hs_cyc;
        repeat (3) tick();
        startLine = 7'd3;
        for (int i = 0; i < 50 && hs_count < h0 + 2; i++) tick();
        startValid = 1'b0;
        chk("held_start_count", 32'(hs_count), 32'(h0 + 2));
        chk("restart_gap", 32'(hs_cyc - t1), 32'(LW + 3));
        run_until_idle(8'hFF);

        outReady = 1'b1;
        do_start(4);
        for (int i = 0; i < 50 && pops_in_line < 3; i++) tick();
        chk("pops_before_rst", 32'(pops_in_line), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outValid", 32'(outValid), 32'd0);
        chk("midrst_startReady", 32'(startReady), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle_valid", 32'(outValid), 32'd0);
        end
        do_start(4);
        run_until_idle(8'hFF);
        chk("fresh_line_first", 32'(first_pop - hs_cyc), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
